// File: rtl/mini_alu_core.sv
// mini_alu_core: single-issue MiniALU execution core with a one-stage decode
// register, a parametrised register file, a multi-level return stack and a
// stalling valid/ready write port into the VGA video RAM.
//
// Optional feature macro: MINI_ALU_MULHI_EN
//   defined   -> SMUL also writes the high product half to register dst+1
//   undefined -> the high product half is discarded
//
// Ports:
//   Clock        system clock, all state on the rising edge
//   Reset        asynchronous active-low reset
//   oIP          registered fetch address to the instruction ROM
//   iInstruction ROM[oIP], combinational; {op[3:0], dst[7:0], src1[7:0], src0[7:0]}
//   oVramValid   video RAM write request
//   iVramReady   video RAM accepts the request this cycle
//   oVramRow     write row    (reg[src0] low bits, latched at issue)
//   oVramCol     write column (reg[src1] low bits, latched at issue)
//   oVramColor   write colour (colour register, latched at issue)
//   oStackErr    sticky return-stack overflow/underflow flag
module mini_alu_core #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned IP_W        = 16,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned ROW_W       = 6,
    parameter int unsigned COL_W       = 7
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [IP_W-1:0]  oIP,
    input  logic [27:0]      iInstruction,
    output logic             oVramValid,
    input  logic             iVramReady,
    output logic [ROW_W-1:0] oVramRow,
    output logic [COL_W-1:0] oVramCol,
    output logic [2:0]       oVramColor,
    output logic             oStackErr
);

    localparam int unsigned INSTR_W   = 28;
    localparam int unsigned REG_DEPTH = 1 << REG_ADDR_W;
    localparam int unsigned SP_W      = $clog2(STACK_DEPTH + 1);
    localparam int unsigned STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_STO  = 4'h3;
    localparam logic [3:0] OP_BLE  = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_SMUL = 4'h7;
    localparam logic [3:0] OP_CALL = 4'h8;
    localparam logic [3:0] OP_RET  = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_RGB  = 4'hC;
    localparam logic [3:0] OP_STC  = 4'hD;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] decInstr;
    logic [IP_W-1:0]    decIp;
    logic [DATA_W-1:0]  regFile  [REG_DEPTH];
    logic [IP_W-1:0]    retStack [STACK_DEPTH];
    logic [SP_W-1:0]    stackPtr;
    logic [2:0]         colour;

    // ------------------------------------------------------------------
    // Decode-register field split and operand reads
    // ------------------------------------------------------------------
    logic [3:0]            opCode;
    logic [7:0]            dstField;
    logic [7:0]            src1Field;
    logic [7:0]            src0Field;
    logic [REG_ADDR_W-1:0] dstIdx;
    logic [REG_ADDR_W-1:0] src1Idx;
    logic [REG_ADDR_W-1:0] src0Idx;
    logic [DATA_W-1:0]     rdS1;
    logic [DATA_W-1:0]     rdS0;
    logic [15:0]           immRaw;
    logic [DATA_W-1:0]     immVal;
    logic [IP_W-1:0]       jumpTarget;
    logic [IP_W-1:0]       callReturn;

    assign {opCode, dstField, src1Field, src0Field} = decInstr;
    assign dstIdx     = dstField[REG_ADDR_W-1:0];
    assign src1Idx    = src1Field[REG_ADDR_W-1:0];
    assign src0Idx    = src0Field[REG_ADDR_W-1:0];
    assign rdS1       = regFile[src1Idx];
    assign rdS0       = regFile[src0Idx];
    assign immRaw     = {src1Field, src0Field};
    assign immVal     = DATA_W'(immRaw);
    assign jumpTarget = IP_W'(dstField);
    assign callReturn = decIp + IP_W'(1);

    // Multiplier: keep the upper half only when something consumes it
    logic [DATA_W-1:0] mulLo;
`ifdef MINI_ALU_MULHI_EN
    logic [2*DATA_W-1:0]   mulFull;
    logic [DATA_W-1:0]     mulHi;
    logic [REG_ADDR_W-1:0] hiIdx;
    logic                  hiWrEn;
    assign mulFull = {{DATA_W{1'b0}}, rdS1} * {{DATA_W{1'b0}}, rdS0};
    assign mulLo   = mulFull[DATA_W-1:0];
    assign mulHi   = mulFull[2*DATA_W-1:DATA_W];
    assign hiIdx   = dstIdx + REG_ADDR_W'(1);
`else
    assign mulLo   = rdS1 * rdS0;
`endif

    // ------------------------------------------------------------------
    // Return-stack pointers
    // ------------------------------------------------------------------
    logic                 stackFull;
    logic                 stackEmpty;
    logic [STK_IDX_W-1:0] pushIdx;
    logic [STK_IDX_W-1:0] topIdx;

    assign stackFull  = (stackPtr == SP_W'(STACK_DEPTH));
    assign stackEmpty = (stackPtr == '0);
    assign pushIdx    = STK_IDX_W'(stackPtr);
    assign topIdx     = STK_IDX_W'(stackPtr - SP_W'(1));

    // Core advances unless a VRAM write is pending and not yet accepted
    logic advance;
    assign advance = ~(oVramValid & ~iVramReady);

    // ------------------------------------------------------------------
    // Execute stage: decode the instruction held in the decode register
    // ------------------------------------------------------------------
    logic              wrEn;
    logic [DATA_W-1:0] wrData;
    logic              branchTaken;
    logic [IP_W-1:0]   branchTarget;
    logic              pushEn;
    logic              popEn;
    logic              errSet;
    logic              rgbEn;
    logic              stcIssue;

    always_comb begin
        wrEn         = 1'b0;
        wrData       = '0;
        branchTaken  = 1'b0;
        branchTarget = jumpTarget;
        pushEn       = 1'b0;
        popEn        = 1'b0;
        errSet       = 1'b0;
        rgbEn        = 1'b0;
        stcIssue     = 1'b0;
`ifdef MINI_ALU_MULHI_EN
        hiWrEn       = 1'b0;
`endif
        case (opCode)
            OP_ADD: begin
                wrEn   = 1'b1;
                wrData = rdS1 + rdS0;
            end
            OP_SUB: begin
                wrEn   = 1'b1;
                wrData = rdS1 - rdS0;
            end
            OP_STO: begin
                wrEn   = 1'b1;
                wrData = immVal;
            end
            OP_BLE:  branchTaken = (rdS1 <= rdS0);
            OP_BEQ:  branchTaken = (rdS1 == rdS0);
            OP_JMP:  branchTaken = 1'b1;
            OP_SMUL: begin
                wrEn   = 1'b1;
                wrData = mulLo;
`ifdef MINI_ALU_MULHI_EN
                hiWrEn = 1'b1;
`endif
            end
            OP_CALL: begin
                // A full stack still branches; only the return address is lost
                branchTaken = 1'b1;
                pushEn      = ~stackFull;
                errSet      = stackFull;
            end
            OP_RET: begin
                // An empty stack turns RET into a NOP
                branchTaken  = ~stackEmpty;
                branchTarget = retStack[topIdx];
                popEn        = ~stackEmpty;
                errSet       = stackEmpty;
            end
            OP_INC: begin
                wrEn   = 1'b1;
                wrData = rdS1 + DATA_W'(1);
            end
            OP_MOV: begin
                wrEn   = 1'b1;
                wrData = rdS1;
            end
            OP_RGB:  rgbEn    = 1'b1;
            OP_STC:  stcIssue = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch / decode pipeline; a taken branch flushes the fetched word
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oIP      <= '0;
            decInstr <= NOP_INSTR;
            decIp    <= '0;
        end else if (advance) begin
            decIp <= oIP;
            if (branchTaken) begin
                oIP      <= branchTarget;
                decInstr <= NOP_INSTR;
            end else begin
                oIP      <= oIP + IP_W'(1);
                decInstr <= iInstruction;
            end
        end
    end

    // Register file write port(s)
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(REG_DEPTH); i++) begin
                regFile[i] <= '0;
            end
        end else if (advance) begin
            if (wrEn) begin
                regFile[dstIdx] <= wrData;
            end
`ifdef MINI_ALU_MULHI_EN
            if (hiWrEn) begin
                regFile[hiIdx] <= mulHi;
            end
`endif
        end
    end

    // Return stack and its sticky error flag
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stackPtr  <= '0;
            oStackErr <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                retStack[i] <= '0;
            end
        end else if (advance) begin
            if (pushEn) begin
                retStack[pushIdx] <= callReturn;
                stackPtr          <= stackPtr + SP_W'(1);
            end else if (popEn) begin
                stackPtr <= stackPtr - SP_W'(1);
            end
            if (errSet) begin
                oStackErr <= 1'b1;
            end
        end
    end

    // Colour register and VRAM write request; payload frozen while stalled
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            colour     <= '0;
            oVramValid <= 1'b0;
            oVramRow   <= '0;
            oVramCol   <= '0;
            oVramColor <= '0;
        end else if (advance) begin
            if (rgbEn) begin
                colour <= src1Field[2:0];
            end
            oVramValid <= stcIssue;
            if (stcIssue) begin
                oVramRow   <= rdS0[ROW_W-1:0];
                oVramCol   <= rdS1[COL_W-1:0];
                oVramColor <= colour;
            end
        end
    end

endmodule

// File: tb/tb_mini_alu_core.sv
// Self-checking bench for mini_alu_core: directed ROM programs, VRAM writes
// checked by a scoreboard monitor, fetch/stall/reset behaviour checked inline.
module tb_mini_alu_core;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned REG_ADDR_W  = 4;
    localparam int unsigned IP_W        = 16;
    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned ROW_W       = 6;
    localparam int unsigned COL_W       = 7;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [2:0]       color;
        logic             err;
    } vram_exp_t;

    logic             Clock;
    logic             Reset;
    logic [IP_W-1:0]  oIP;
    logic [27:0]      iInstruction;
    logic             oVramValid;
    logic             iVramReady;
    logic [ROW_W-1:0] oVramRow;
    logic [COL_W-1:0] oVramCol;
    logic [2:0]       oVramColor;
    logic             oStackErr;

    logic [27:0] rom [256];
    vram_exp_t   sb [$];
    int          checkCount;
    int          failCount;

    mini_alu_core #(
        .DATA_W      (DATA_W),
        .REG_ADDR_W  (REG_ADDR_W),
        .IP_W        (IP_W),
        .STACK_DEPTH (STACK_DEPTH),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .oIP          (oIP),
        .iInstruction (iInstruction),
        .oVramValid   (oVramValid),
        .iVramReady   (iVramReady),
        .oVramRow     (oVramRow),
        .oVramCol     (oVramCol),
        .oVramColor   (oVramColor),
        .oStackErr    (oStackErr)
    );

    assign iInstruction = rom[oIP[7:0]];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] ins(input int op, input int dst, input int s1, input int s0);
        return {4'(op), 8'(dst), 8'(s1), 8'(s0)};
    endfunction

    function automatic vram_exp_t mkExp(input int row, input int col, input int color, input int err);
        vram_exp_t e;
        e.row   = ROW_W'(row);
        e.col   = COL_W'(col);
        e.color = 3'(color);
        e.err   = 1'(err);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare every accepted VRAM write against the queue
    always @(negedge Clock) begin
        #1;
        if (Reset && oVramValid && iVramReady) begin
            if (sb.size() == 0) begin
                checkCount++;
                failCount++;
                $display("FAIL vram_unexpected: got row=0x%0h col=0x%0h color=%0d, expected no write",
                         oVramRow, oVramCol, oVramColor);
            end else begin
                vram_exp_t e;
                e = sb.pop_front();
                check("vram_row",   32'(oVramRow),   32'(e.row));
                check("vram_col",   32'(oVramCol),   32'(e.col));
                check("vram_color", 32'(oVramColor), 32'(e.color));
                check("vram_err",   32'(oStackErr),  32'(e.err));
            end
        end
    end

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic applyReset();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_ip",    32'(oIP),        32'h0);
        check("rst_valid", 32'(oVramValid), 32'h0);
        check("rst_row",   32'(oVramRow),   32'h0);
        check("rst_col",   32'(oVramCol),   32'h0);
        check("rst_color", 32'(oVramColor), 32'h0);
        check("rst_err",   32'(oStackErr),  32'h0);
        Reset = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        check(name, 32'(sb.size()), 32'h0);
        repeat (4) @(negedge Clock);
    endtask

    initial begin
        logic [IP_W-1:0] ipExp [10];
        logic [IP_W-1:0] ip0;
        int              n;

        checkCount = 0;
        failCount  = 0;
        Reset      = 1'b0;
        iVramReady = 1'b1;
        clearRom();

        // ---- Phase 1: STO/ADD/SUB, fetch order, BLE taken with flush ----
        rom[0]    = ins(3, 1, 0, 5);
        rom[1]    = ins(3, 2, 0, 3);
        rom[2]    = ins(1, 3, 1, 2);
        rom[3]    = ins(13, 0, 3, 3);
        rom[4]    = ins(2, 4, 2, 1);
        rom[5]    = ins(13, 0, 4, 4);
        rom[6]    = ins(3, 1, 0, 3);
        rom[7]    = ins(4, 8'h20, 1, 2);
        rom[8]    = ins(3, 3, 0, 8'h77);
        rom[8'h20] = ins(13, 0, 3, 3);
        rom[8'h21] = ins(6, 8'h21, 0, 0);
        sb.push_back(mkExp(8, 8, 0, 0));
        sb.push_back(mkExp(8'h3E, 8'h7E, 0, 0));
        sb.push_back(mkExp(8, 8, 0, 0));
        ipExp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'h20, 16'h21};
        applyReset();
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            check($sformatf("ip_seq[%0d]", k), 32'(oIP), 32'(ipExp[k]));
        end
        drain("p1_drain");

        // ---- Phase 2: nested CALL/RET, then stack overflow ----
        clearRom();
        rom[0]     = ins(8, 8'h10, 0, 0);
        rom[1]     = ins(3, 5, 0, 8'h0A);
        rom[2]     = ins(13, 0, 6, 5);
        rom[3]     = ins(6, 8'h40, 0, 0);
        rom[8'h10] = ins(8, 8'h20, 0, 0);
        rom[8'h11] = ins(3, 6, 0, 8'h0B);
        rom[8'h12] = ins(9, 0, 0, 0);
        rom[8'h13] = ins(3, 6, 0, 8'h3F);
        rom[8'h20] = ins(3, 7, 0, 8'h0C);
        rom[8'h21] = ins(13, 0, 7, 7);
        rom[8'h22] = ins(9, 0, 0, 0);
        rom[8'h23] = ins(3, 7, 0, 8'h3F);
        for (int a = 8'h40; a < 8'h45; a++) rom[a] = ins(8, a + 1, 0, 0);
        rom[8'h45] = ins(13, 0, 7, 7);
        rom[8'h46] = ins(6, 8'h46, 0, 0);
        sb.push_back(mkExp(12, 12, 0, 0));
        sb.push_back(mkExp(10, 11, 0, 0));
        sb.push_back(mkExp(12, 12, 0, 1));
        applyReset();
        drain("p2_drain");
        check("p2_overflow_err", 32'(oStackErr), 32'h1);
        check("p2_loop_ip", 32'(oIP >= 16'h45 && oIP <= 16'h47), 32'h1);

        // ---- Phase 3: RET on empty, RGB+STC stall, SMUL ----
        clearRom();
        iVramReady = 1'b0;
        rom[0]     = ins(9, 0, 0, 0);
        rom[1]     = ins(3, 1, 0, 7);
        rom[2]     = ins(3, 2, 0, 12);
        rom[3]     = ins(12, 0, 5, 0);
        rom[4]     = ins(13, 0, 2, 1);
        rom[5]     = ins(3, 3, 8'h12, 8'h34);
        rom[6]     = ins(3, 4, 8'h01, 8'h00);
        rom[7]     = ins(7, 8, 3, 4);
        rom[8]     = ins(3, 10, 8'h34, 8'h00);
        rom[9]     = ins(5, 8'h20, 8, 10);
        rom[10]    = ins(13, 0, 1, 1);
        rom[11]    = ins(6, 11, 0, 0);
`ifdef MINI_ALU_MULHI_EN
        rom[8'h20] = ins(3, 11, 0, 8'h12);
`else
        rom[8'h20] = ins(3, 11, 0, 0);
`endif
        rom[8'h21] = ins(5, 8'h28, 9, 11);
        rom[8'h22] = ins(13, 0, 1, 1);
        rom[8'h23] = ins(6, 8'h23, 0, 0);
        rom[8'h28] = ins(13, 0, 8, 8);
        rom[8'h29] = ins(6, 8'h29, 0, 0);
        sb.push_back(mkExp(7, 12, 5, 1));
        sb.push_back(mkExp(0, 0, 5, 1));
        applyReset();
        n = 0;
        while (!oVramValid && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("stall_seen", 32'(oVramValid), 32'h1);
        check("stall_ip", 32'(oIP), 32'h6);
        ip0 = oIP;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall_valid[%0d]", c), 32'(oVramValid), 32'h1);
            check($sformatf("stall_ipfrozen[%0d]", c), 32'(oIP), 32'(ip0));
            check($sformatf("stall_row[%0d]", c), 32'(oVramRow), 32'h7);
            check($sformatf("stall_col[%0d]", c), 32'(oVramCol), 32'hC);
            check($sformatf("stall_color[%0d]", c), 32'(oVramColor), 32'h5);
            if (c == 3) iVramReady = 1'b1;
            @(negedge Clock);
        end
        check("stall_release_valid", 32'(oVramValid), 32'h0);
        check("stall_release_ip", 32'(oIP), 32'(ip0 + 16'd1));
        drain("p3_drain");

        // ---- Phase 4: reset asserted during an STC stall ----
        clearRom();
        iVramReady = 1'b0;
        rom[0] = ins(3, 1, 0, 9);
        rom[1] = ins(13, 0, 1, 1);
        rom[2] = ins(6, 2, 0, 0);
        applyReset();
        n = 0;
        while (!oVramValid && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("p4_stall_seen", 32'(oVramValid), 32'h1);
        check("p4_row", 32'(oVramRow), 32'h9);
        #2 Reset = 1'b0;
        #1;
        check("arst_ip",    32'(oIP),        32'h0);
        check("arst_valid", 32'(oVramValid), 32'h0);
        check("arst_row",   32'(oVramRow),   32'h0);
        check("arst_col",   32'(oVramCol),   32'h0);
        check("arst_color", 32'(oVramColor), 32'h0);
        check("arst_err",   32'(oStackErr),  32'h0);
        @(negedge Clock);
        Reset = 1'b1;
        check("p4_resume_ip0", 32'(oIP), 32'h0);
        @(negedge Clock);
        check("p4_resume_ip1", 32'(oIP), 32'h1);
        sb.push_back(mkExp(9, 9, 0, 0));
        iVramReady = 1'b1;
        drain("p4_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mini_alu_core.md
Name: mini_alu_core

Overview:
- Parametrised successor to the single-level-return MiniALU execution core.
- Fetches 28-bit instructions from an external combinational ROM and executes them through a one-stage decode register.
- Holds a parametrised register file and a multi-level return stack (nested CALL/RET).
- Drives the video RAM write port through a valid/ready handshake that stalls the core.
- Sits between the instruction ROM and the VGA video RAM in place of the previous core.

Parameters:
- DATA_W, 16, register and ALU data width.
- REG_ADDR_W, 4, register-file address bits; low bits of each 8-bit instruction field; depth 2**REG_ADDR_W.
- IP_W, 16, instruction pointer width.
- STACK_DEPTH, 4, return-stack entries (>=1).
- ROW_W, 6, VRAM row address width.
- COL_W, 7, VRAM column address width.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- oIP  out  IP_W  fetch address to instruction ROM, registered.
- iInstruction  in  28  ROM[oIP], combinational; [27:24] op, [23:16] dst, [15:8] src1, [7:0] src0.
- oVramValid  out  1  VRAM write request.
- iVramReady  in  1  VRAM accepts the request this cycle.
- oVramRow  out  ROW_W  write row, taken from reg[src0] low bits.
- oVramCol  out  COL_W  write column, taken from reg[src1] low bits.
- oVramColor  out  3  RGB write data, the colour register.
- oStackErr  out  1  sticky return-stack overflow/underflow flag.

Behaviour:
- Reset (async assert, sync release): oIP=0, decode register=NOP, all registers=0, stack pointer=0, colour=0, oVramValid=0, oVramRow=0, oVramCol=0, oStackErr=0.
- Pipeline, each non-stalled cycle:
  - decode register <= iInstruction.
  - oIP <= oIP+1, or the branch target when a branch is taken.
  - The execute stage acts on the decode register.
  - Register reads are combinational; register writes happen on the edge.
  - A write is visible to the following instruction; no forwarding is needed.
- Branch taken: oIP <= target, and the decode register is loaded with NOP (flushes the wrong-path instruction). Penalty is 1 bubble.
- Opcodes (dst, s1, s0 are the low REG_ADDR_W bits of the fields; imm = {src1,src0} zero-extended/truncated to DATA_W):
  - 0 NOP.
  - 1 ADD: dst = s1 + s0, mod 2**DATA_W.
  - 2 SUB: dst = s1 - s0, wrap.
  - 3 STO: dst = imm.
  - 4 BLE: branch to dst field when s1 <= s0, unsigned.
  - 5 BEQ: branch to dst field when s1 == s0.
  - 6 JMP: branch to dst field.
  - 7 SMUL: dst = low DATA_W bits of s1*s0, unsigned.
  - 8 CALL: push (decode-instruction IP + 1), branch to dst field.
  - 9 RET: pop, branch to popped address.
  - A INC: dst = s1 + 1.
  - B MOV: dst = s1.
  - C RGB: colour <= src1 field [2:0].
  - D STC: VRAM write.
  - E, F: NOP.
- Branch targets: the 8-bit dst field is zero-extended to IP_W.
- Decode IP: the decode register carries its own fetch IP (oIP value when latched).
- Return stack, LIFO:
  - CALL when full: still branches, push dropped, oStackErr <= 1.
  - RET when empty: not taken (behaves as NOP), oStackErr <= 1.
  - oStackErr clears only on Reset.
- STC handshake:
  - Cycle after STC enters execute: oVramValid=1 with row/col/colour latched at issue.
  - Core stalls (oIP, decode register, registers hold) until iVramReady=1. Transfer completes on that edge; oVramValid drops next cycle unless the next instruction is also STC.
  - Outputs stay stable while valid and not ready.
  - RGB immediately before STC supplies the new colour.
- Reset mid-stall drops oVramValid immediately.

Optional Feature:
- Macro MINI_ALU_MULHI_EN.
- Defined: SMUL also writes the high DATA_W bits of the product to register (dst+1) mod depth, in the same cycle.
- Undefined: the high half is discarded.

Test Plan:
- Reset release, ROM: STO r1,5; STO r2,3; ADD r3,r1,r2 -> r3=8, oIP sequence 0,1,2,3.
- SUB r4,r2,r1 (3-5) at DATA_W=16 -> r4=16'hFFFE; BLE with r1=3,r2=3 taken to 0x20 -> oIP=0x20 after 1 bubble; the flushed instruction has no effect.
- Nested CALL 0x10 -> CALL 0x20 -> RET -> RET -> returns to 0x11 then to caller+1; the fifth nested CALL at STACK_DEPTH=4 sets oStackErr=1; RET on empty does not branch.
- RGB 3'b101; STC with reg row=7, col=12; hold iVramReady=0 for 3 cycles -> oVramValid=1 for 4 cycles with row=7/col=12/colour=5; oIP frozen; advances after ready.
- SMUL 0x1234*0x0100 -> dst=0x3400; with MINI_ALU_MULHI_EN, dst+1=0x0012.
- Assert Reset during an STC stall -> all outputs 0 asynchronously; fetch resumes at oIP=0.
